// File: rtl/atan_share_arbiter.sv
// ---------------------------------------------------------------------------
// atan_share_arbiter
//
// Shares one multi-cycle qarctan unit between NUM_REQ demodulator requesters.
// A round-robin pick in IDLE accepts one (x, y) pair, the pair is issued to
// the shared unit with a one-cycle start, and the result (or a timeout error
// if the unit never answers) is returned to the owner as a one-cycle pulse.
//
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   req_valid    - per-requester operand pending
//   req_x, req_y - flattened operands, slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    - one-hot combinational accept (IDLE only)
//   rsp_valid    - one-hot registered result pulse to the owner
//   rsp_data     - result, meaningful only with rsp_valid
//   rsp_err      - timeout flag, qualifies rsp_valid
//   atan_start   - registered one-cycle start to the shared unit
//   atan_x/y     - latched operands to the shared unit
//   atan_data    - shared unit result
//   atan_valid   - shared unit result strobe
//   busy         - arbiter is not in IDLE
// ---------------------------------------------------------------------------
module atan_share_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_x,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_y,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic                          atan_start,
    output logic [DATA_WIDTH-1:0]         atan_x,
    output logic [DATA_WIDTH-1:0]         atan_y,
    input  logic [DATA_WIDTH-1:0]         atan_data,
    input  logic                          atan_valid,
    output logic                          busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDX_W:0]   NUM_REQ_EXT = (IDX_W+1)'(NUM_REQ);
    localparam logic [TMR_W-1:0] TIMER_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } state_t;

    state_t                 state_q,      state_d;
    logic [IDX_W-1:0]       lastGrant_q,  lastGrant_d;
    logic [IDX_W-1:0]       owner_q,      owner_d;
    logic [DATA_WIDTH-1:0]  x_q,          x_d;
    logic [DATA_WIDTH-1:0]  y_q,          y_d;
    logic [DATA_WIDTH-1:0]  result_q,     result_d;
    logic                   err_q,        err_d;
    logic [TMR_W-1:0]       timer_q,      timer_d;
    logic                   atanStart_q,  atanStart_d;
    logic [NUM_REQ-1:0]     rspValid_q,   rspValid_d;

    logic                   grantFound;
    logic [IDX_W-1:0]       grantIdx;
    logic [IDX_W:0]         candSum;
    logic [IDX_W-1:0]       candIdx;
    logic                   handshake;

    // Round-robin scan starting one past the last served requester. The sum
    // is one bit wider so the wrap can be done with a single subtract.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        candSum    = '0;
        candIdx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            candSum = {1'b0, lastGrant_q} + (IDX_W+1)'(k);
            if (candSum >= NUM_REQ_EXT) begin
                candSum = candSum - NUM_REQ_EXT;
            end
            candIdx = candSum[IDX_W-1:0];
            if (!grantFound && req_valid[candIdx]) begin
                grantFound = 1'b1;
                grantIdx   = candIdx;
            end
        end
    end

    // Accept is only offered in IDLE; it is masked during reset so every
    // output reads zero while reset is held.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grantFound && !reset) begin
            req_ready = NUM_REQ'(1) << grantIdx;
        end
    end

    assign handshake = |(req_valid & req_ready);

    // Next-state and registered-output logic. atan_start and rsp_valid are
    // computed one cycle early so that they are flop outputs in ISSUE and
    // RESPOND respectively. A result strobe outside WAIT is never looked at.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        owner_d     = owner_q;
        x_d         = x_q;
        y_d         = y_q;
        result_d    = result_q;
        err_d       = err_q;
        timer_d     = timer_q;
        atanStart_d = 1'b0;
        rspValid_d  = '0;

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    x_d         = req_x[int'(grantIdx)*DATA_WIDTH +: DATA_WIDTH];
                    y_d         = req_y[int'(grantIdx)*DATA_WIDTH +: DATA_WIDTH];
                    owner_d     = grantIdx;
                    atanStart_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A result arriving on the timeout cycle still counts as good.
                if (atan_valid) begin
                    result_d   = atan_data;
                    err_d      = 1'b0;
                    rspValid_d = NUM_REQ'(1) << owner_q;
                    state_d    = RESPOND;
                end else if (timer_q == TIMER_LAST) begin
                    result_d   = '0;
                    err_d      = 1'b1;
                    rspValid_d = NUM_REQ'(1) << owner_q;
                    state_d    = RESPOND;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESPOND: begin
                // err doubles as the rsp_err pulse, so drop it on the way out.
                lastGrant_d = owner_q;
                err_d       = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset restores requester 0 as first in line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lastGrant_q <= IDX_W'(NUM_REQ - 1);
            owner_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            timer_q     <= '0;
            atanStart_q <= 1'b0;
            rspValid_q  <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            owner_q     <= owner_d;
            x_q         <= x_d;
            y_q         <= y_d;
            result_q    <= result_d;
            err_q       <= err_d;
            timer_q     <= timer_d;
            atanStart_q <= atanStart_d;
            rspValid_q  <= rspValid_d;
        end
    end

    assign atan_start = atanStart_q;
    assign atan_x     = x_q;
    assign atan_y     = y_q;
    assign rsp_valid  = rspValid_q;
    assign rsp_data   = result_q;
    assign rsp_err    = err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/atan_share_arbiter.md
Name: atan_share_arbiter

Overview:
- Round-robin arbiter that shares one multi-cycle qarctan unit (start/valid_out handshake) between NUM_REQ demodulator requesters.
- Each requester presents one (x, y) operand pair. The arbiter issues it to the shared unit, waits for the result, then returns it to the owning requester with a one-cycle pulse.
- A watchdog aborts operations whose result never arrives, so the shared unit cannot hang the radio pipeline.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_WIDTH, 32, operand and result width.
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT before abort (>= 2).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  requester i has an operand pair pending.
- req_x  input  NUM_REQ*DATA_WIDTH  flattened x operands; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_y  input  NUM_REQ*DATA_WIDTH  flattened y operands.
- req_ready  output  NUM_REQ  one-hot accept; handshake = req_valid[i] & req_ready[i].
- rsp_valid  output  NUM_REQ  one-hot, one-cycle result pulse to owner.
- rsp_data  output  DATA_WIDTH  result; valid only with rsp_valid.
- rsp_err  output  1  timeout flag; qualifies rsp_valid.
- atan_start  output  1  one-cycle start to the shared qarctan.
- atan_x  output  DATA_WIDTH  latched x to the shared unit.
- atan_y  output  DATA_WIDTH  latched y to the shared unit.
- atan_data  input  DATA_WIDTH  shared unit result.
- atan_valid  input  1  shared unit result strobe.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- Reset values: state=IDLE, last_grant=NUM_REQ-1 (requester 0 has first priority), owner=0, latched operands=0, result=0, err=0, timer=0. All outputs are 0 during and after reset.
- IDLE:
  - Choose the first i with req_valid[i]=1, scanning from last_grant+1 modulo NUM_REQ.
  - req_ready[i] is asserted combinationally in the same cycle; all other req_ready bits stay 0.
  - On handshake: latch req_x/req_y slice i, set owner=i, go to ISSUE.
  - If no request is pending, req_ready is all 0.
- ISSUE: atan_start=1 for exactly one cycle; atan_x/atan_y are driven from the latches; clear timer; go to WAIT.
- WAIT:
  - atan_x/atan_y are held stable; timer increments each cycle.
  - atan_valid=1: capture atan_data, err=0, go to RESPOND.
  - Otherwise, when timer reaches TIMEOUT_CYCLES-1: result=0, err=1, go to RESPOND.
  - If atan_valid and timeout occur in the same cycle, valid wins (err=0).
- RESPOND:
  - rsp_valid[owner]=1 for one cycle, with rsp_data=result and rsp_err=err.
  - Set last_grant=owner; go to IDLE.
  - There is no response backpressure; requesters must sink the pulse.
- atan_valid arriving in IDLE, ISSUE or RESPOND is ignored; it does not corrupt the result register.
- Latency: handshake at cycle T, atan_start at T+1. With unit latency L (atan_valid at T+1+L), rsp_valid is at T+2+L.
- Throughput: one operation per L+3 cycles; the arbiter accepts no new request until back in IDLE.
- req_valid dropping after the handshake has no effect.
- A requester that keeps req_valid high re-arbitrates normally; round-robin guarantees every active requester is served within NUM_REQ grants.
- Outputs atan_start, rsp_valid and rsp_err are registered; req_ready is combinational from state, last_grant and req_valid.
- Reset mid-operation aborts immediately with no response pulse. The shared qarctan is reset by the same reset.

Test Plan:
- Single request: reset, then req_valid[0]=1 with x=0x00000100, y=0x00000100. Stub unit returns 0x0000_3244 after L=5. Required: req_ready[0] in the request cycle, atan_start one cycle later, rsp_valid=2'b01 with rsp_data=0x00003244 and rsp_err=0 exactly 7 cycles after the handshake.
- Contention: req_valid=2'b11 held continuously, L=3. Required: grants alternate 0,1,0,1; each rsp_valid goes to the matching owner; 6-cycle spacing between grants.
- Timeout: TIMEOUT_CYCLES=8, stub never asserts atan_valid. Required: rsp_valid[owner]=1, rsp_err=1, rsp_data=0 on the cycle after timer reaches 7; the arbiter returns to IDLE and accepts the next request.
- Valid/timeout collision: atan_valid asserted on the cycle timer=TIMEOUT_CYCLES-1. Required: rsp_err=0 and rsp_data equals atan_data.
- Stray valid plus mid-operation reset: pulse atan_valid in IDLE (no response, busy=0). Then reset during WAIT: all outputs are 0 on the next cycle, no rsp_valid is emitted, and requester 0 wins first after reset.
